// File: rtl/vector_addsub_issue_ctrl_pkg.sv
// Shared types and SEW decode for the vector add/sub issue controller.
// Operand width defaults to the platform maximum vector length.
package vector_addsub_pkg;

    localparam int MAX_VLEN = 512;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        DONE = 2'b10
    } addsub_state_t;

    localparam logic [1:0] SEW8        = 2'b00;
    localparam logic [1:0] SEW16       = 2'b01;
    localparam logic [1:0] SEW32       = 2'b10;
    localparam logic [1:0] SEW_ILLEGAL = 2'b11;

    // Returns {sew_32, sew_16_32} for the datapath.
    function automatic logic [1:0] sew_to_ctrl(input logic [1:0] vsew);
        logic [1:0] ctrl;
        ctrl = 2'b00;
        case (vsew)
            SEW8:    ctrl = 2'b00;
            SEW16:   ctrl = 2'b01;
            SEW32:   ctrl = 2'b11;
            default: ctrl = 2'b01;
        endcase
        return ctrl;
    endfunction

endpackage

// File: rtl/vector_addsub_issue_ctrl_tail_mask.sv
// Byte-enable generator: byte j is active when its element index is below vl.
// Element index is the byte index shifted right by vsew.
module vector_tail_byte_mask
    import vector_addsub_pkg::*;
#(
    parameter int VLEN = MAX_VLEN,
    parameter int VL_W = $clog2(VLEN / 8) + 1
) (
    input  logic [1:0]          vsew,
    input  logic [VL_W-1:0]     vl,
    output logic [VLEN/8-1:0]   byte_en
);

    localparam int NBYTES = VLEN / 8;

    // Compare each byte's element index against the active length.
    always_comb begin
        byte_en = '0;
        for (int j = 0; j < NBYTES; j++) begin
            byte_en[j] = ((32'(j) >> vsew) < 32'(vl));
        end
    end

endmodule

// File: rtl/vector_addsub_issue_ctrl.sv
// Issue controller for the combinational vector add/sub datapath: latches a request,
// drives the datapath, merges tail-undisturbed elements and hands the result to writeback.
module vector_addsub_issue_ctrl
    import vector_addsub_pkg::*;
#(
    parameter int VLEN = MAX_VLEN,
    parameter int VL_W = $clog2(VLEN / 8) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_sub,
    input  logic [1:0]       in_vsew,
    input  logic [VL_W-1:0]  in_vl,
    input  logic [VLEN-1:0]  in_vs1,
    input  logic [VLEN-1:0]  in_vs2,
    input  logic [VLEN-1:0]  in_vd_old,
    output logic             dp_ctrl,
    output logic             dp_sew_16_32,
    output logic             dp_sew_32,
    output logic [VLEN-1:0]  dp_a,
    output logic [VLEN-1:0]  dp_b,
    input  logic [VLEN-1:0]  dp_sum,
    input  logic             dp_done,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [VLEN-1:0]  out_data,
    output logic             out_err
);

    localparam int NBYTES = VLEN / 8;

    addsub_state_t     state_r;
    addsub_state_t     state_s;
    logic              in_ready_r;
    logic              out_valid_r;
    logic              sub_r;
    logic [1:0]        vsew_r;
    logic [VL_W-1:0]   vl_r;
    logic [VLEN-1:0]   vs1_r;
    logic [VLEN-1:0]   vs2_r;
    logic [VLEN-1:0]   vd_old_r;
    logic [VLEN-1:0]   out_data_r;
    logic              out_err_r;
    logic [NBYTES-1:0] byte_en_s;
    logic [VLEN-1:0]   merged_s;

    vector_tail_byte_mask #(
        .VLEN (VLEN),
        .VL_W (VL_W)
    ) u_tail_mask (
        .vsew    (vsew_r),
        .vl      (vl_r),
        .byte_en (byte_en_s)
    );

    // Next-state logic; illegal SEW bypasses the datapath.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (in_valid) begin
                    if (in_vsew == SEW_ILLEGAL) begin
                        state_s = DONE;
                    end else begin
                        state_s = EXEC;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            EXEC: state_s = DONE;
            DONE: begin
                if (out_ready) begin
                    state_s = IDLE;
                end else begin
                    state_s = DONE;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // State register and registered handshake outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= IDLE;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            state_r     <= state_s;
            in_ready_r  <= (state_s == IDLE);
            out_valid_r <= (state_s == DONE);
        end
    end

    // Per-byte tail merge: inactive bytes keep the old destination.
    always_comb begin
        merged_s = vd_old_r;
        for (int j = 0; j < NBYTES; j++) begin
            if (byte_en_s[j]) begin
                merged_s[8*j +: 8] = dp_sum[8*j +: 8];
            end else begin
                merged_s[8*j +: 8] = vd_old_r[8*j +: 8];
            end
        end
    end

    // Operand capture on acceptance and result capture at the end of EXEC.
    always_ff @(posedge clk) begin
        if (reset) begin
            sub_r      <= 1'b0;
            vsew_r     <= 2'b00;
            vl_r       <= '0;
            vs1_r      <= '0;
            vs2_r      <= '0;
            vd_old_r   <= '0;
            out_data_r <= '0;
            out_err_r  <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        sub_r    <= in_sub;
                        vsew_r   <= in_vsew;
                        vl_r     <= in_vl;
                        vs1_r    <= in_vs1;
                        vs2_r    <= in_vs2;
                        vd_old_r <= in_vd_old;
                        if (in_vsew == SEW_ILLEGAL) begin
                            out_data_r <= in_vd_old;
                            out_err_r  <= 1'b1;
                        end
                    end
                end
                EXEC: begin
                    out_data_r <= merged_s;
                    out_err_r  <= ~dp_done;
                end
                default: begin
                    out_data_r <= out_data_r;
                    out_err_r  <= out_err_r;
                end
            endcase
        end
    end

    assign in_ready                    = in_ready_r;
    assign out_valid                   = out_valid_r;
    assign out_data                    = out_data_r;
    assign out_err                     = out_err_r;
    assign dp_a                        = vs2_r;
    assign dp_b                        = vs1_r;
    assign dp_ctrl                     = sub_r;
    assign {dp_sew_32, dp_sew_16_32}   = sew_to_ctrl(vsew_r);

endmodule

// File: tb/tb_vector_addsub_issue_ctrl.sv
// Directed bench for vector_addsub_issue_ctrl with a behavioural add/sub datapath stub.
// Table vectors cover SEW/vl/tail corners; hand sequences cover backpressure and reset.
module tb_vector_addsub_issue_ctrl;
    import vector_addsub_pkg::*;

    localparam int VLEN = 512;
    localparam int VL_W = $clog2(VLEN / 8) + 1;
    localparam int NVEC = 10;

    logic             clk;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic             in_sub;
    logic [1:0]       in_vsew;
    logic [VL_W-1:0]  in_vl;
    logic [VLEN-1:0]  in_vs1;
    logic [VLEN-1:0]  in_vs2;
    logic [VLEN-1:0]  in_vd_old;
    logic             dp_ctrl;
    logic             dp_sew_16_32;
    logic             dp_sew_32;
    logic [VLEN-1:0]  dp_a;
    logic [VLEN-1:0]  dp_b;
    logic [VLEN-1:0]  dp_sum;
    logic             dp_done;
    logic             done_en;
    logic             out_valid;
    logic             out_ready;
    logic [VLEN-1:0]  out_data;
    logic             out_err;

    int checks;
    int errors;

    typedef struct {
        logic            sub;
        logic [1:0]      vsew;
        logic [VL_W-1:0] vl;
        logic [VLEN-1:0] vs1;
        logic [VLEN-1:0] vs2;
        logic [VLEN-1:0] vd_old;
        logic [VLEN-1:0] exp_data;
        logic            exp_err;
        int              exp_lat;
        logic            no_done;
    } vec_t;

    vec_t vecs [NVEC];

    vector_addsub_issue_ctrl #(.VLEN(VLEN), .VL_W(VL_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_sub       (in_sub),
        .in_vsew      (in_vsew),
        .in_vl        (in_vl),
        .in_vs1       (in_vs1),
        .in_vs2       (in_vs2),
        .in_vd_old    (in_vd_old),
        .dp_ctrl      (dp_ctrl),
        .dp_sew_16_32 (dp_sew_16_32),
        .dp_sew_32    (dp_sew_32),
        .dp_a         (dp_a),
        .dp_b         (dp_b),
        .dp_sum       (dp_sum),
        .dp_done      (dp_done),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_err      (out_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Datapath stub: lane-wise modular add/sub at the requested element width.
    always_comb begin
        dp_sum = '0;
        if (dp_sew_32) begin
            for (int i = 0; i < VLEN / 32; i++)
                dp_sum[32*i +: 32] = dp_ctrl ? dp_a[32*i +: 32] - dp_b[32*i +: 32]
                                             : dp_a[32*i +: 32] + dp_b[32*i +: 32];
        end else if (dp_sew_16_32) begin
            for (int i = 0; i < VLEN / 16; i++)
                dp_sum[16*i +: 16] = dp_ctrl ? dp_a[16*i +: 16] - dp_b[16*i +: 16]
                                             : dp_a[16*i +: 16] + dp_b[16*i +: 16];
        end else begin
            for (int i = 0; i < VLEN / 8; i++)
                dp_sum[8*i +: 8] = dp_ctrl ? dp_a[8*i +: 8] - dp_b[8*i +: 8]
                                           : dp_a[8*i +: 8] + dp_b[8*i +: 8];
        end
    end
    assign dp_done = done_en;

    task automatic chk_vec(input string name, input logic [VLEN-1:0] act, input logic [VLEN-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    task automatic chk_bit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %b want %b", name, act, exp);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d want %0d", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic sub, input logic [1:0] vsew, input int vl,
                                input logic [VLEN-1:0] vs1, input logic [VLEN-1:0] vs2,
                                input logic [VLEN-1:0] vd_old, input logic [VLEN-1:0] exp_data,
                                input logic exp_err, input int exp_lat, input logic no_done);
        vec_t v;
        v.sub = sub; v.vsew = vsew; v.vl = VL_W'(vl);
        v.vs1 = vs1; v.vs2 = vs2; v.vd_old = vd_old;
        v.exp_data = exp_data; v.exp_err = exp_err; v.exp_lat = exp_lat; v.no_done = no_done;
        return v;
    endfunction

    task automatic drive_req(input logic sub, input logic [1:0] vsew, input logic [VL_W-1:0] vl,
                             input logic [VLEN-1:0] vs1, input logic [VLEN-1:0] vs2,
                             input logic [VLEN-1:0] vd_old);
        in_sub = sub; in_vsew = vsew; in_vl = vl;
        in_vs1 = vs1; in_vs2 = vs2; in_vd_old = vd_old;
        in_valid = 1'b1;
    endtask

    // Waits for out_valid; returns the cycle index (acceptance edge = N, first sample = N+1).
    task automatic wait_valid(output int lat);
        lat = 1;
        while (!out_valid && lat < 8) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic run_vec(input vec_t v);
        int lat;
        done_en = ~v.no_done;
        drive_req(v.sub, v.vsew, v.vl, v.vs1, v.vs2, v.vd_old);
        chk_bit("in_ready_idle", in_ready, 1'b1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_vs1 = ~v.vs1; in_vs2 = ~v.vs2; in_vd_old = ~v.vd_old;
        chk_bit("in_ready_busy", in_ready, 1'b0);
        wait_valid(lat);
        chk_int("latency", lat, v.exp_lat);
        chk_vec("out_data", out_data, v.exp_data);
        chk_bit("out_err", out_err, v.exp_err);
        chk_bit("dp_sew_32", dp_sew_32, v.vsew == 2'b10);
        chk_bit("dp_sew_16_32", dp_sew_16_32, v.vsew != 2'b00);
        chk_bit("dp_ctrl", dp_ctrl, v.sub);
        chk_vec("dp_a", dp_a, v.vs2);
        chk_vec("dp_b", dp_b, v.vs1);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk_bit("out_valid_drop", out_valid, 1'b0);
        chk_bit("in_ready_back", in_ready, 1'b1);
        done_en = 1'b1;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        logic [VLEN-1:0] bp_exp;
        checks = 0; errors = 0;
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; done_en = 1'b1;
        in_sub = 1'b0; in_vsew = 2'b00; in_vl = '0;
        in_vs1 = '0; in_vs2 = '0; in_vd_old = '0;

        vecs[0] = mk(1'b0, 2'b10, 16, {16{32'h00000001}}, {16{32'h7FFFFFFF}}, {16{32'h0BADF00D}},
                     {16{32'h80000000}}, 1'b0, 2, 1'b0);
        vecs[1] = mk(1'b1, 2'b00, 3, {64{8'h07}}, {64{8'h05}}, {64{8'hAA}},
                     {{61{8'hAA}}, {3{8'hFE}}}, 1'b0, 2, 1'b0);
        vecs[2] = mk(1'b0, 2'b01, 0, {32{16'h0001}}, {32{16'h00FF}}, {32{16'h1234}},
                     {32{16'h1234}}, 1'b0, 2, 1'b0);
        vecs[3] = mk(1'b0, 2'b11, 10, {64{8'h11}}, {64{8'h22}}, {16{32'hDEADBEEF}},
                     {16{32'hDEADBEEF}}, 1'b1, 1, 1'b0);
        vecs[4] = mk(1'b0, 2'b00, 10, {64{8'h03}}, {64{8'h20}}, {64{8'h00}},
                     {{54{8'h00}}, {10{8'h23}}}, 1'b1, 2, 1'b1);
        vecs[5] = mk(1'b0, 2'b01, 5, {32{16'h0001}}, {32{16'h00FF}}, {32{16'h1234}},
                     {{27{16'h1234}}, {5{16'h0100}}}, 1'b0, 2, 1'b0);
        vecs[6] = mk(1'b1, 2'b10, 100, {16{32'h00000001}}, {16{32'h00000000}}, {16{32'h33333333}},
                     {16{32'hFFFFFFFF}}, 1'b0, 2, 1'b0);
        vecs[7] = mk(1'b0, 2'b00, 64, {64{8'h02}}, {64{8'hFF}}, {64{8'h77}},
                     {64{8'h01}}, 1'b0, 2, 1'b0);
        vecs[8] = mk(1'b0, 2'b10, 1, {16{32'h00000001}}, {16{32'h0000FFFF}}, {16{32'h55555555}},
                     {{15{32'h55555555}}, 32'h00010000}, 1'b0, 2, 1'b0);
        vecs[9] = mk(1'b1, 2'b01, 32, {32{16'h0001}}, {32{16'h0000}}, {32{16'h4444}},
                     {32{16'hFFFF}}, 1'b0, 2, 1'b0);

        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_bit("rst_in_ready", in_ready, 1'b1);
        chk_bit("rst_out_valid", out_valid, 1'b0);
        chk_bit("rst_out_err", out_err, 1'b0);
        chk_vec("rst_out_data", out_data, '0);
        chk_vec("rst_dp_a", dp_a, '0);
        chk_vec("rst_dp_b", dp_b, '0);
        chk_bit("rst_dp_ctrl", dp_ctrl, 1'b0);
        chk_bit("rst_dp_sew_16_32", dp_sew_16_32, 1'b0);
        chk_bit("rst_dp_sew_32", dp_sew_32, 1'b0);

        for (int i = 0; i < NVEC; i++) begin
            run_vec(vecs[i]);
        end

        // Backpressure: result held for 5 cycles while a competing request is offered.
        bp_exp = {64{8'h11}};
        drive_req(1'b0, 2'b00, 7'd64, {64{8'h01}}, {64{8'h10}}, {64{8'h99}});
        @(posedge clk); #1;
        drive_req(1'b1, 2'b11, 7'd5, {64{8'hC3}}, {64{8'h3C}}, {64{8'h5A}});
        wait_valid(lat);
        chk_int("bp_latency", lat, 2);
        for (int c = 0; c < 5; c++) begin
            chk_bit("bp_out_valid", out_valid, 1'b1);
            chk_vec("bp_out_data", out_data, bp_exp);
            chk_bit("bp_out_err", out_err, 1'b0);
            chk_bit("bp_in_ready", in_ready, 1'b0);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        chk_vec("bp_dp_a_kept", dp_a, {64{8'h10}});
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            chk_bit("bp_no_extra", out_valid, 1'b0);
            @(posedge clk); #1;
        end

        // Reset while in EXEC: transaction aborted, nothing emitted.
        drive_req(1'b0, 2'b10, 7'd16, {16{32'h1}}, {16{32'h2}}, {16{32'h3}});
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk_bit("exec_busy", in_ready, 1'b0);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk_bit("abort_out_valid", out_valid, 1'b0);
        chk_bit("abort_in_ready", in_ready, 1'b1);
        chk_vec("abort_out_data", out_data, '0);
        chk_vec("abort_dp_a", dp_a, '0);
        out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            chk_bit("abort_no_result", out_valid, 1'b0);
        end
        out_ready = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vector_addsub_issue_ctrl.md
Name: vector_addsub_issue_ctrl

Overview:
Sequential front-end for the combinational vector add/sub datapath (vector_adder_subtractor).
- Accepts one vadd/vsub request per transaction over a valid/ready handshake from the vector decode stage.
- Registers the operands and decodes vsew into the datapath's sew_16_32/sew_32 controls.
- Captures the datapath result and merges tail elements (index ≥ vl) from vd_old, tail-undisturbed.
- Presents the result to writeback over a second valid/ready handshake.

Parameters:
VLEN, `MAX_VLEN, vector register width in bits; must be a multiple of 32
VL_W, $clog2(VLEN/8)+1, width of vl (max element count at SEW=8)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
in_valid  in  1  request valid
in_ready  out  1  block can accept a request
in_sub  in  1  0=vadd (vs2+vs1), 1=vsub (vs2-vs1)
in_vsew  in  2  00=SEW8, 01=SEW16, 10=SEW32, 11=illegal
in_vl  in  VL_W  active element count
in_vs1  in  VLEN  operand vs1
in_vs2  in  VLEN  operand vs2
in_vd_old  in  VLEN  old destination contents (tail source)
dp_ctrl  out  1  to datapath Ctrl
dp_sew_16_32  out  1  to datapath sew_16_32
dp_sew_32  out  1  to datapath sew_32
dp_a  out  VLEN  to datapath A (vs2)
dp_b  out  VLEN  to datapath B (vs1)
dp_sum  in  VLEN  from datapath Sum
dp_done  in  1  from datapath sum_done
out_valid  out  1  result valid
out_ready  in  1  writeback accepts result
out_data  out  VLEN  merged result
out_err  out  1  illegal SEW or datapath not done

Behaviour:
- Clocking and reset:
  - Single clock clk.
  - reset is synchronous and active-high.
- Reset values:
  - State = IDLE.
  - in_ready=1, out_valid=0, out_err=0, out_data=0.
  - All operand registers = 0, so dp_* outputs = 0.
- FSM states: IDLE, EXEC, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid && in_ready, latch in_sub, in_vsew, in_vl, vs1, vs2, vd_old.
  - Legal vsew: go to EXEC.
  - vsew=11: go directly to DONE with out_data=vd_old and out_err=1.
- EXEC:
  - in_ready=0.
  - dp_* are driven combinationally from the registers:
    - dp_a=vs2_q, dp_b=vs1_q, dp_ctrl=sub_q.
    - dp_sew_16_32=(vsew_q!=00), dp_sew_32=(vsew_q==10).
  - At the end of the cycle, capture out_data = per-byte merge (active byte ? dp_sum : vd_old_q).
  - Set out_err = !dp_done, then go to DONE.
- DONE:
  - out_valid=1; out_data and out_err are held stable while out_valid && !out_ready.
  - On out_ready, go to IDLE, and out_valid falls the next cycle.
- Latency and throughput:
  - A request accepted at edge N produces out_valid high from cycle N+2 (legal SEW) or N+1 (illegal SEW).
  - Non-pipelined: one transaction in flight. in_ready is high only in IDLE, so acceptance and out_valid never coincide.
- Tail mask:
  - Byte j (0..VLEN/8-1) is active iff (j >> vsew_q) < vl_q.
  - vl=0: out_data = vd_old entirely, out_err=0, full EXEC/DONE sequence still taken.
  - vl ≥ VLEN/SEW: all bytes active (no wrap, no error).
- Arithmetic is modulo 2^SEW per element, with no saturation and no overflow flag (performed by the datapath).
- in_* inputs are ignored outside IDLE.
- dp_* holds the last latched operands while in DONE and IDLE.
- Reset asserted in any state aborts the transaction with no output, and returns all outputs to their reset values on the next edge.

Decomposition:
- Package vector_addsub_pkg:
  - typedef enum logic [1:0] {IDLE, EXEC, DONE} addsub_state_t.
  - Constants SEW8=2'b00, SEW16=2'b01, SEW32=2'b10.
  - function sew_to_ctrl(vsew) returning {sew_32, sew_16_32}.
- Sub-module vector_tail_byte_mask: combinational, (vsew, vl) → VLEN/8-bit byte-enable, instantiated once.

Test Plan:
- Reset, then idle 3 cycles: in_ready=1, out_valid=0, out_data=0, all dp_*=0.
- SEW32 vadd, vl=16, lane0 vs2=0x7FFFFFFF, vs1=1: out_valid at N+2, lane0=0x80000000, dp_sew_32=1, dp_sew_16_32=1, out_err=0.
- SEW8 vsub, vl=3, all bytes vs2=0x05, vs1=0x07, vd_old=0xAA: bytes 0-2=0xFE, bytes 3..63=0xAA.
- SEW16 vadd, lane vs2=0x00FF, vs1=0x0001, vl=0: out_data==vd_old, out_err=0.
- Illegal vsew=11: out_valid at N+1, out_err=1, out_data=vd_old. Repeat with a datapath stub forcing dp_done=0 at SEW8: out_err=1.
- Backpressure and reset:
  - Hold out_ready=0 for 5 cycles: out_valid/out_data stable, in_ready=0, a new in_valid is not accepted.
  - Assert reset during EXEC: next cycle state IDLE, out_valid=0, no result ever emitted.
